// File: rtl/bus_timer_irq_pkg.sv
// Shared constants for the bus_timer_irq responder: register offsets, CTRL/IFR/IER bit indices.
// The writable CTRL mask depends on the TIMER_CHAIN_EN build option.
package bus_timer_irq_pkg;

   localparam logic [2:0] OFF_T1L  = 3'd0;
   localparam logic [2:0] OFF_T1H  = 3'd1;
   localparam logic [2:0] OFF_T2L  = 3'd2;
   localparam logic [2:0] OFF_T2H  = 3'd3;
   localparam logic [2:0] OFF_CTRL = 3'd4;
   localparam logic [2:0] OFF_IFR  = 3'd5;
   localparam logic [2:0] OFF_IER  = 3'd6;

   localparam int CTRL_T1EN    = 0;
   localparam int CTRL_T1CONT  = 1;
   localparam int CTRL_T2EN    = 2;
   localparam int CTRL_T2CONT  = 3;
   localparam int CTRL_PSEN    = 4;
   localparam int CTRL_T2CHAIN = 5;

   localparam int IFR_T1  = 0;
   localparam int IFR_T2  = 1;
   localparam int IFR_IRQ = 7;
   localparam int IER_T1  = 0;
   localparam int IER_T2  = 1;

   localparam logic [15:0] TMR_RESET = 16'hFFFF;

`ifdef TIMER_CHAIN_EN
   localparam logic [5:0] CTRL_WMASK = 6'h3F;
`else
   localparam logic [5:0] CTRL_WMASK = 6'h1F;
`endif

endpackage

// File: rtl/bus_timer_irq_core.sv
// timer16_core: one 16-bit down counter with reload latch, byte-wise load and
// underflow / one-shot auto-disable strobes for the enclosing register block.
module timer16_core
   import bus_timer_irq_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        lo_we_i,
   input  logic        hi_we_i,
   input  logic [7:0]  wdata_i,
   input  logic        tick_i,
   input  logic        en_i,
   input  logic        cont_i,
   output logic [15:0] cnt_o,
   output logic        uflow_o,
   output logic        disable_o
);

   logic [15:0] latch_q, latch_d;
   logic [15:0] cnt_q, cnt_d;
   logic        zero_s;
   logic        uflow_s;

   // A hi-byte write on the underflow edge suppresses the underflow entirely.
   assign zero_s    = (cnt_q == 16'h0000);
   assign uflow_s   = tick_i & en_i & zero_s & ~hi_we_i;
   assign uflow_o   = uflow_s;
   assign disable_o = uflow_s & ~cont_i;
   assign cnt_o     = cnt_q;

   // Next-state for latch and counter.
   always_comb begin
      latch_d = latch_q;
      cnt_d   = cnt_q;
      if (lo_we_i) begin
         latch_d = {latch_q[15:8], wdata_i};
      end else if (hi_we_i) begin
         latch_d = {wdata_i, latch_q[7:0]};
      end else begin
         latch_d = latch_q;
      end
      if (hi_we_i) begin
         cnt_d = {wdata_i, latch_q[7:0]};
      end else if (tick_i && en_i) begin
         if (zero_s) begin
            cnt_d = latch_q;
         end else begin
            cnt_d = cnt_q - 16'd1;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter and latch registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         latch_q <= TMR_RESET;
         cnt_q   <= TMR_RESET;
      end else begin
         latch_q <= latch_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/bus_timer_irq.sv
// Memory-mapped dual 16-bit timer with shared prescaler and level irq on the 6502 bus.
// Build option TIMER_CHAIN_EN adds CTRL bit5 (T2CHAIN): T2 ticks on T1 underflows.
module bus_timer_irq
   import bus_timer_irq_pkg::*;
#(
   parameter logic [15:0] BASE     = 16'hD000,
   parameter int          PRESCALE = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] address,
   input  logic        write,
   input  logic [7:0]  data_i,
   output logic [7:0]  data_o,
   output logic        sel,
   output logic        irq
);

   localparam logic [7:0] PS_MAX = 8'(PRESCALE - 1);

   logic        sel_s, wr_s, rd_s;
   logic [2:0]  off_s;
   logic [7:0]  ps_q, ps_d;
   logic [5:0]  ctrl_q, ctrl_d;
   logic [1:0]  ifr_q, ifr_d, ier_q, ier_d, clr_s, set_s;
   logic        irq_q;
   logic        tick_s, t2_tick_s;
   logic [15:0] t1_cnt_s, t2_cnt_s;
   logic        t1_uflow_s, t2_uflow_s, t1_dis_s, t2_dis_s;

   assign sel_s  = (address[15:3] == BASE[15:3]);
   assign off_s  = address[2:0];
   assign wr_s   = sel_s & write;
   assign rd_s   = sel_s & ~write;
   assign sel    = sel_s;
   assign irq    = irq_q;
   assign tick_s = ctrl_q[CTRL_PSEN] ? (ps_q == PS_MAX) : 1'b1;

`ifdef TIMER_CHAIN_EN
   assign t2_tick_s = ctrl_q[CTRL_T2CHAIN] ? t1_uflow_s : tick_s;
`else
   assign t2_tick_s = tick_s;
`endif

   timer16_core u_t1 (
      .clk       (clk),
      .reset_n   (reset_n),
      .lo_we_i   (wr_s && (off_s == OFF_T1L)),
      .hi_we_i   (wr_s && (off_s == OFF_T1H)),
      .wdata_i   (data_i),
      .tick_i    (tick_s),
      .en_i      (ctrl_q[CTRL_T1EN]),
      .cont_i    (ctrl_q[CTRL_T1CONT]),
      .cnt_o     (t1_cnt_s),
      .uflow_o   (t1_uflow_s),
      .disable_o (t1_dis_s)
   );

   timer16_core u_t2 (
      .clk       (clk),
      .reset_n   (reset_n),
      .lo_we_i   (wr_s && (off_s == OFF_T2L)),
      .hi_we_i   (wr_s && (off_s == OFF_T2H)),
      .wdata_i   (data_i),
      .tick_i    (t2_tick_s),
      .en_i      (ctrl_q[CTRL_T2EN]),
      .cont_i    (ctrl_q[CTRL_T2CONT]),
      .cnt_o     (t2_cnt_s),
      .uflow_o   (t2_uflow_s),
      .disable_o (t2_dis_s)
   );

   // Control/flag next state; flag sets override clears, CTRL writes override auto-disable.
   always_comb begin
      ps_d  = (ps_q == PS_MAX) ? 8'h00 : ps_q + 8'h01;
      clr_s = ({2{wr_s && (off_s == OFF_IFR)}} & data_i[1:0])
            | {(rd_s && (off_s == OFF_T2L)) || (wr_s && (off_s == OFF_T2H)),
               (rd_s && (off_s == OFF_T1L)) || (wr_s && (off_s == OFF_T1H))};
      set_s = {t2_uflow_s, t1_uflow_s};
      ifr_d = (ifr_q & ~clr_s) | set_s;
      ier_d = (wr_s && (off_s == OFF_IER)) ? data_i[1:0] : ier_q;
      if (wr_s && (off_s == OFF_CTRL)) begin
         ctrl_d = data_i[5:0] & CTRL_WMASK;
      end else begin
         ctrl_d            = ctrl_q;
         ctrl_d[CTRL_T1EN] = ctrl_q[CTRL_T1EN] & ~t1_dis_s;
         ctrl_d[CTRL_T2EN] = ctrl_q[CTRL_T2EN] & ~t2_dis_s;
      end
   end

   // Register block state; irq follows flag state one clock later.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ps_q   <= 8'h00;
         ctrl_q <= 6'h00;
         ifr_q  <= 2'b00;
         ier_q  <= 2'b00;
         irq_q  <= 1'b0;
      end else begin
         ps_q   <= ps_d;
         ctrl_q <= ctrl_d;
         ifr_q  <= ifr_d;
         ier_q  <= ier_d;
         irq_q  <= |(ifr_q & ier_q);
      end
   end

   // Combinational read mux; CPU samples it in the same cycle as the address.
   always_comb begin
      data_o = 8'h00;
      if (sel_s && !write) begin
         case (off_s)
            OFF_T1L:  data_o = t1_cnt_s[7:0];
            OFF_T1H:  data_o = t1_cnt_s[15:8];
            OFF_T2L:  data_o = t2_cnt_s[7:0];
            OFF_T2H:  data_o = t2_cnt_s[15:8];
            OFF_CTRL: data_o = {2'b00, ctrl_q};
            OFF_IFR:  data_o = {irq_q, 5'b00000, ifr_q};
            OFF_IER:  data_o = {6'b000000, ier_q};
            default:  data_o = 8'h00;
         endcase
      end else begin
         data_o = 8'h00;
      end
   end

endmodule

// File: tb/tb_bus_timer_irq.sv
// Self-checking bench for bus_timer_irq: directed scenarios plus randomized bus traffic
// compared against a behavioural model of the register map and timers.
module tb_bus_timer_irq;

   localparam int PRESCALE = 16;
`ifdef TIMER_CHAIN_EN
   localparam bit CHAIN = 1'b1;
`else
   localparam bit CHAIN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] address;
   logic        write;
   logic [7:0]  data_i, data_o;
   logic        sel, irq;

   int passed = 0;
   int total  = 0;

   logic [15:0] m_cnt[2], m_latch[2];
   bit          m_en[2], m_cont[2];
   bit          m_psen, m_chain, m_irq;
   logic [1:0]  m_ifr, m_ier;
   int          m_ps;

   logic [7:0]  got_rd, exp_rd;
   logic        got_irq, exp_irq, got_sel, exp_sel;

   bus_timer_irq #(.BASE(16'hD000), .PRESCALE(PRESCALE)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .address (address),
      .write   (write),
      .data_i  (data_i),
      .data_o  (data_o),
      .sel     (sel),
      .irq     (irq)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      for (int n = 0; n < 2; n++) begin
         m_cnt[n] = 16'hFFFF; m_latch[n] = 16'hFFFF; m_en[n] = 1'b0; m_cont[n] = 1'b0;
      end
      m_psen = 1'b0; m_chain = 1'b0; m_irq = 1'b0;
      m_ifr = 2'b00; m_ier = 2'b00; m_ps = 0;
   endtask

   function automatic logic [7:0] model_read(input logic [15:0] a, input logic w);
      if (a[15:3] != 13'h1A00 || w) return 8'h00;
      case (a[2:0])
         3'd0: return m_cnt[0][7:0];
         3'd1: return m_cnt[0][15:8];
         3'd2: return m_cnt[1][7:0];
         3'd3: return m_cnt[1][15:8];
         3'd4: return {2'b00, m_chain, m_psen, m_cont[1], m_en[1], m_cont[0], m_en[0]};
         3'd5: return {m_irq, 5'b00000, m_ifr};
         3'd6: return {6'b000000, m_ier};
         default: return 8'h00;
      endcase
   endfunction

   // One clock of the register-map rules applied to the model.
   task automatic model_step(input logic [15:0] a, input logic w, input logic [7:0] d);
      bit s, tick, nirq;
      bit hiw[2], low[2], tk[2], uf[2];
      int off;
      s    = (a[15:3] == 13'h1A00);
      off  = int'(a[2:0]);
      nirq = ((m_ifr & m_ier) != 2'b00);
      tick = !m_psen || (m_ps == PRESCALE - 1);
      m_ps = (m_ps + 1) % PRESCALE;
      for (int n = 0; n < 2; n++) begin
         hiw[n] = s && w && (off == 2 * n + 1);
         low[n] = s && w && (off == 2 * n);
      end
      tk[0] = tick;
      uf[0] = tk[0] && m_en[0] && (m_cnt[0] == 16'h0000) && !hiw[0];
      tk[1] = m_chain ? uf[0] : tick;
      uf[1] = tk[1] && m_en[1] && (m_cnt[1] == 16'h0000) && !hiw[1];
      for (int n = 0; n < 2; n++) begin
         if (hiw[n]) begin
            m_latch[n][15:8] = d;
            m_cnt[n] = m_latch[n];
         end else if (tk[n] && m_en[n]) begin
            m_cnt[n] = (m_cnt[n] == 16'h0000) ? m_latch[n] : m_cnt[n] - 16'd1;
         end
         if (low[n]) m_latch[n][7:0] = d;
         if (uf[n] && !m_cont[n]) m_en[n] = 1'b0;
      end
      if (s && w && off == 5) m_ifr = m_ifr & ~d[1:0];
      if (s && !w && off == 0) m_ifr[0] = 1'b0;
      if (s && !w && off == 2) m_ifr[1] = 1'b0;
      for (int n = 0; n < 2; n++) begin
         if (hiw[n]) m_ifr[n] = 1'b0;
         if (uf[n]) m_ifr[n] = 1'b1;
      end
      if (s && w && off == 4) begin
         m_en[0] = d[0]; m_cont[0] = d[1]; m_en[1] = d[2]; m_cont[1] = d[3];
         m_psen = d[4]; m_chain = CHAIN && d[5];
      end
      if (s && w && off == 6) m_ier = d[1:0];
      m_irq = nirq;
   endtask

   // Drive one bus cycle, sample outputs, advance the model alongside the DUT.
   task automatic cycle(input logic [15:0] a, input logic w, input logic [7:0] d);
      address = a; write = w; data_i = d;
      #1;
      got_rd = data_o; got_irq = irq; got_sel = sel;
      exp_rd = model_read(a, w); exp_irq = m_irq; exp_sel = (a[15:3] == 13'h1A00);
      model_step(a, w, d);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      cycle(16'hD006, 1'b1, 8'h01);
      cycle(16'hD000, 1'b1, 8'h00);
      cycle(16'hD001, 1'b1, 8'h00);
      cycle(16'hD004, 1'b1, 8'h01);
      for (int k = 0; k < 3; k++) cycle(16'hD007, 1'b0, 8'h00);
      total++;
      if (got_irq !== 1'b1) $display("FAIL pre_reset_irq: got %b expected 1", got_irq);
      else passed++;
      reset_n = 1'b0;
      #1;
      total++;
      if (irq !== 1'b0) $display("FAIL async_reset_irq: got %b expected 0", irq);
      else passed++;
      model_reset();
      @(negedge clk); @(negedge clk);
      reset_n = 1'b1;
      cycle(16'hD000, 1'b0, 8'h00);
      total++;
      if (got_rd !== 8'hFF) $display("FAIL reset_t1lo: got %h expected ff", got_rd); else passed++;
      cycle(16'hD001, 1'b0, 8'h00);
      total++;
      if (got_rd !== 8'hFF) $display("FAIL reset_t1hi: got %h expected ff", got_rd); else passed++;
      cycle(16'hD004, 1'b0, 8'h00);
      total++;
      if (got_rd !== 8'h00) $display("FAIL reset_ctrl: got %h expected 00", got_rd); else passed++;
      cycle(16'hD005, 1'b0, 8'h00);
      total++;
      if (got_rd !== 8'h00) $display("FAIL reset_ifr: got %h expected 00", got_rd); else passed++;
      total++;
      if (got_irq !== 1'b0) $display("FAIL reset_irq: got %b expected 0", got_irq); else passed++;
      cycle(16'hD010, 1'b0, 8'h00);
      total++;
      if (got_sel !== 1'b0 || got_rd !== 8'h00)
         $display("FAIL offblock_read: got sel=%b data=%h expected sel=0 data=00", got_sel, got_rd);
      else passed++;
   endtask

   task automatic test_continuous();
      int ks[$];
      int first_irq;
      bit clr;
      first_irq = 0; clr = 1'b0;
      cycle(16'hD000, 1'b1, 8'h03);
      cycle(16'hD001, 1'b1, 8'h00);
      cycle(16'hD006, 1'b1, 8'h01);
      cycle(16'hD004, 1'b1, 8'h03);
      for (int k = 1; k <= 20; k++) begin
         if (clr) begin
            cycle(16'hD005, 1'b1, 8'h01);
            clr = 1'b0;
         end else begin
            cycle(16'hD005, 1'b0, 8'h00);
            if (got_rd[0]) begin ks.push_back(k); clr = 1'b1; end
         end
         if (first_irq == 0 && got_irq) first_irq = k;
      end
      total++;
      if (ks.size() < 4) $display("FAIL cont_events: got %0d expected >=4", ks.size());
      else begin
         passed++;
         total++;
         if (ks[0] != 5) $display("FAIL cont_first: got cycle %0d expected 5", ks[0]); else passed++;
         for (int i = 1; i < 4; i++) begin
            total++;
            if (ks[i] - ks[i-1] != 4)
               $display("FAIL cont_period: got %0d expected 4", ks[i] - ks[i-1]);
            else passed++;
         end
      end
      total++;
      if (first_irq != 6) $display("FAIL cont_irq_first: got cycle %0d expected 6", first_irq);
      else passed++;
      cycle(16'hD004, 1'b1, 8'h00);
      cycle(16'hD005, 1'b1, 8'h03);
   endtask

   task automatic test_oneshot();
      bit again;
      again = 1'b0;
      cycle(16'hD001, 1'b1, 8'h00);
      cycle(16'hD004, 1'b1, 8'h01);
      for (int k = 0; k < 10; k++) cycle(16'hD005, 1'b0, 8'h00);
      total++;
      if (got_rd[0] !== 1'b1) $display("FAIL oneshot_set: got %h expected bit0=1", got_rd); else passed++;
      cycle(16'hD005, 1'b1, 8'h01);
      for (int k = 0; k < 10; k++) begin
         cycle(16'hD005, 1'b0, 8'h00);
         if (got_rd[0]) again = 1'b1;
      end
      total++;
      if (again) $display("FAIL oneshot_once: got second flag expected none"); else passed++;
      cycle(16'hD004, 1'b0, 8'h00);
      total++;
      if (got_rd !== 8'h00) $display("FAIL oneshot_ctrl: got %h expected 00", got_rd); else passed++;
      cycle(16'hD001, 1'b0, 8'h00);
      total++;
      if (got_rd !== 8'h00) $display("FAIL oneshot_hi: got %h expected 00", got_rd); else passed++;
      cycle(16'hD000, 1'b0, 8'h00);
      total++;
      if (got_rd !== 8'h03) $display("FAIL oneshot_lo: got %h expected 03", got_rd); else passed++;
   endtask

   task automatic test_flag_clear();
      cycle(16'hD001, 1'b1, 8'h00);
      cycle(16'hD004, 1'b1, 8'h03);
      for (int k = 1; k <= 3; k++) cycle(16'hD007, 1'b0, 8'h00);
      cycle(16'hD005, 1'b1, 8'h01);
      cycle(16'hD005, 1'b0, 8'h00);
      total++;
      if (got_rd[0] !== 1'b1) $display("FAIL set_beats_clear: got %h expected bit0=1", got_rd); else passed++;
      cycle(16'hD000, 1'b0, 8'h00);
      cycle(16'hD005, 1'b0, 8'h00);
      total++;
      if (got_rd[0] !== 1'b0) $display("FAIL lo_read_clear: got %h expected bit0=0", got_rd); else passed++;
      cycle(16'hD007, 1'b0, 8'h00);
      cycle(16'hD005, 1'b0, 8'h00);
      cycle(16'hD005, 1'b1, 8'h01);
      cycle(16'hD005, 1'b0, 8'h00);
      total++;
      if (got_rd[0] !== 1'b0) $display("FAIL w1c_clear: got %h expected bit0=0", got_rd); else passed++;
      cycle(16'hD007, 1'b0, 8'h00);
      total++;
      if (got_irq !== 1'b0) $display("FAIL irq_drop: got %b expected 0", got_irq); else passed++;
      cycle(16'hD004, 1'b1, 8'h00);
      cycle(16'hD005, 1'b1, 8'h03);
   endtask

   task automatic test_back_to_back();
      cycle(16'hD000, 1'b1, 8'h02);
      cycle(16'hD001, 1'b1, 8'h00);
      cycle(16'hD006, 1'b1, 8'h00);
      cycle(16'hD004, 1'b1, 8'h03);
      cycle(16'hD007, 1'b0, 8'h00);
      cycle(16'hD007, 1'b0, 8'h00);
      cycle(16'hD001, 1'b1, 8'h05);
      cycle(16'hD005, 1'b0, 8'h00);
      total++;
      if (got_rd[0] !== 1'b0) $display("FAIL hiwrite_wins_flag: got %h expected bit0=0", got_rd); else passed++;
      cycle(16'hD001, 1'b0, 8'h00);
      total++;
      if (got_rd !== 8'h05) $display("FAIL hiwrite_reload_hi: got %h expected 05", got_rd); else passed++;
      cycle(16'hD000, 1'b0, 8'h00);
      total++;
      if (got_rd !== 8'h00) $display("FAIL hiwrite_reload_lo: got %h expected 00", got_rd); else passed++;
      cycle(16'hD004, 1'b1, 8'h00);
      cycle(16'hD005, 1'b1, 8'h03);
   endtask

   task automatic test_prescaler();
      int ks[$];
      bit clr;
      clr = 1'b0;
      cycle(16'hD000, 1'b1, 8'h01);
      cycle(16'hD001, 1'b1, 8'h00);
      cycle(16'hD004, 1'b1, 8'h13);
      for (int k = 1; k <= 120; k++) begin
         if (clr) begin
            cycle(16'hD005, 1'b1, 8'h01);
            clr = 1'b0;
         end else begin
            cycle(16'hD005, 1'b0, 8'h00);
            if (got_rd[0]) begin ks.push_back(k); clr = 1'b1; end
         end
      end
      total++;
      if (ks.size() < 3) $display("FAIL ps_events: got %0d expected >=3", ks.size());
      else begin
         passed++;
         for (int i = 1; i < 3; i++) begin
            total++;
            if (ks[i] - ks[i-1] != 2 * PRESCALE)
               $display("FAIL ps_period: got %0d expected %0d", ks[i] - ks[i-1], 2 * PRESCALE);
            else passed++;
         end
      end
      cycle(16'hD004, 1'b1, 8'h00);
      cycle(16'hD005, 1'b1, 8'h03);
   endtask

   task automatic test_chain();
      int ks[$];
      bit clr;
      int per;
      clr = 1'b0;
      per = CHAIN ? 6 : 3;
      cycle(16'hD000, 1'b1, 8'h01);
      cycle(16'hD001, 1'b1, 8'h00);
      cycle(16'hD002, 1'b1, 8'h02);
      cycle(16'hD003, 1'b1, 8'h00);
      cycle(16'hD004, 1'b1, 8'h2F);
      cycle(16'hD004, 1'b0, 8'h00);
      total++;
      if (got_rd !== (CHAIN ? 8'h2F : 8'h0F))
         $display("FAIL chain_ctrl: got %h expected %h", got_rd, (CHAIN ? 8'h2F : 8'h0F));
      else passed++;
      for (int k = 1; k <= 60; k++) begin
         if (clr) begin
            cycle(16'hD005, 1'b1, 8'h02);
            clr = 1'b0;
         end else begin
            cycle(16'hD005, 1'b0, 8'h00);
            if (got_rd[1]) begin ks.push_back(k); clr = 1'b1; end
         end
      end
      total++;
      if (ks.size() < 3) $display("FAIL chain_events: got %0d expected >=3", ks.size());
      else begin
         passed++;
         for (int i = 1; i < 3; i++) begin
            total++;
            if (ks[i] - ks[i-1] != per)
               $display("FAIL chain_period: got %0d expected %0d", ks[i] - ks[i-1], per);
            else passed++;
         end
      end
      cycle(16'hD004, 1'b1, 8'h00);
      cycle(16'hD005, 1'b1, 8'h03);
   endtask

   task automatic test_random();
      logic [15:0] a;
      logic        w;
      logic [7:0]  d;
      for (int k = 0; k < 600; k++) begin
         a = 16'hD000 | 16'($urandom_range(0, 7));
         if ($urandom_range(0, 9) == 0) a = 16'($urandom_range(0, 65535)) ^ 16'h0100;
         w = ($urandom_range(0, 9) < 4);
         d = 8'($urandom_range(0, 255));
         if (a[2:0] == 3'd1 || a[2:0] == 3'd3) d = d & 8'h00;
         cycle(a, w, d);
         total++;
         if (got_rd !== exp_rd || got_irq !== exp_irq || got_sel !== exp_sel)
            $display("FAIL random_k%0d a=%h w=%b: got data=%h irq=%b sel=%b expected data=%h irq=%b sel=%b",
                     k, a, w, got_rd, got_irq, got_sel, exp_rd, exp_irq, exp_sel);
         else passed++;
      end
   endtask

   initial begin
      reset_n = 1'b0; address = 16'h0000; write = 1'b0; data_i = 8'h00;
      model_reset();
      @(negedge clk); @(negedge clk);
      reset_n = 1'b1;
      test_reset();
      test_continuous();
      test_oneshot();
      test_flag_clear();
      test_back_to_back();
      test_prescaler();
      test_chain();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
